// File: rtl/vga_text_attr_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_attr_pipe_pkg
// Description : Shared constants and helpers for the text-mode attribute
//               pixel pipeline.
//               - Default text geometry: 80 columns x 25 rows.
//               - Fixed pipeline latency from input to pixel.
//               - Bit positions of the fg, bg and blink fields in the
//                 attribute byte.
//               - row_base(): the row-to-address shift-add multiplier.
//               Optional feature macro used by the pipeline:
//               TEXT_ATTR_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_text_attr_pipe_pkg;

    localparam int unsigned c_cols           = 80;
    localparam int unsigned c_rows           = 25;
    localparam int unsigned c_pipe_lat       = 4;
    localparam int unsigned c_addr_w         = 11;

    // Attribute byte layout: [7] blink, [6:4] or [7:4] bg, [3:0] fg
    localparam int unsigned c_attr_fg_lsb    = 0;
    localparam int unsigned c_attr_bg_lsb    = 4;
    localparam int unsigned c_attr_blink_bit = 7;

    // row * cols as an 11-bit shift-add; cols is a constant at every call
    // site so this collapses to a handful of adders.
    function automatic logic [10:0] row_base(input logic [4:0] row,
                                             input int unsigned cols);
        logic [10:0] acc;
        acc = '0;
        for (int i = 0; i < 11; i++) begin
            if (cols[i]) begin
                acc = acc + (11'(row) << i);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_attr_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_attr_pipe_if
// Description : Memory-side bus of the text pipeline.
//               Groups the shared character/attribute RAM port and the
//               font ROM port.
//               Signals:
//                 ram_addr  (11) shared char/attr RAM address
//                 ram_cs         RAM enable
//                 char_data (8)  registered char RAM output
//                 attr_data (8)  registered attr RAM output
//                 font_addr (12) {char, scanline}
//                 font_data (8)  font ROM row, bit 7 = leftmost pixel
//               Modports:
//                 master - pipeline side
//                 slave  - memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_text_attr_pipe_if;
    import vga_text_attr_pipe_pkg::*;

    logic [c_addr_w-1:0] ram_addr;
    logic                ram_cs;
    logic [7:0]          char_data;
    logic [7:0]          attr_data;
    logic [11:0]         font_addr;
    logic [7:0]          font_data;

    modport master (
        output ram_addr, ram_cs, font_addr,
        input  char_data, attr_data, font_data
    );

    modport slave (
        input  ram_addr, ram_cs, font_addr,
        output char_data, attr_data, font_data
    );

endinterface
`default_nettype wire

// File: rtl/vga_text_serializer.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_serializer
// Description : Final pipeline stage. Turns one font row into eight pixels
//               and selects the palette index for each of them.
//               Ports:
//                 clk, rst     clock, synchronous active-low reset
//                 i_load       load a new cell at the end of this cycle
//                 i_font_bits  font row (bit 7 = leftmost pixel)
//                 i_attr       attribute byte of the cell
//                 i_cursor     cell is covered by the cursor
//                 i_blink_ph   blink phase sampled at fetch time
//                 i_pix_valid  active-display qualifier aligned to output
//                 o_color      4-bit palette index
//               Macro: TEXT_ATTR_BLINK_EN
//                 defined   - 3-bit bg, attr[7] blinks the foreground
//                 undefined - 4-bit bg, no blinking
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_serializer
    import vga_text_attr_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_font_bits,
    input  logic [7:0] i_attr,
    input  logic       i_cursor,
    input  logic       i_blink_ph,
    input  logic       i_pix_valid,
    output logic [3:0] o_color
);

    logic [7:0] r_shift;
    logic [7:0] r_attr;
    logic       r_cursor;
    logic       r_blink;
    // Pixels left in the current cell; zero means nothing to show, which
    // keeps rows with no fetch (and post-reset cycles) at color 0.
    logic [3:0] r_live;

    logic [3:0] w_fg;
    logic [3:0] w_bg;
    logic [3:0] w_fg_eff;
    logic [3:0] w_pix;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift  <= '0;
            r_attr   <= '0;
            r_cursor <= 1'b0;
            r_blink  <= 1'b0;
            r_live   <= '0;
        end else if (i_load) begin
            r_shift  <= i_font_bits;
            r_attr   <= i_attr;
            r_cursor <= i_cursor;
            r_blink  <= i_blink_ph;
            r_live   <= 4'd8;
        end else begin
            r_shift <= {r_shift[6:0], 1'b0};
            if (r_live != 4'd0) begin
                r_live <= r_live - 4'd1;
            end
        end
    end

    assign w_fg = r_attr[c_attr_fg_lsb +: 4];

`ifdef TEXT_ATTR_BLINK_EN
    assign w_bg     = {1'b0, r_attr[c_attr_bg_lsb +: 3]};
    // Blinking cells hide their foreground during the first half period.
    assign w_fg_eff = (r_attr[c_attr_blink_bit] && !r_blink) ? w_bg : w_fg;
`else
    logic w_unused_blink;
    assign w_bg           = r_attr[c_attr_bg_lsb +: 4];
    assign w_fg_eff       = w_fg;
    assign w_unused_blink = r_blink;
`endif

    // The cursor paints the whole cell row in the raw foreground colour.
    assign w_pix   = r_cursor ? w_fg : (r_shift[7] ? w_fg_eff : w_bg);
    assign o_color = (i_pix_valid && (r_live != 4'd0)) ? w_pix : 4'd0;

endmodule
`default_nettype wire

// File: rtl/vga_text_attr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_attr_pipe
// Description : Text-mode character/attribute pixel pipeline, 4-cycle fixed
//               latency.
//               - Fetches a cell every 8 pixels.
//               - Looks up the font row for the cell.
//               - Serialises the row with fg/bg colouring, cursor overlay
//                 and optional blink.
//               Ports:
//                 clk, rst             pixel clock, sync active-low reset
//                 h_count, v_count     pixel column / scanline
//                 video_on             active-display qualifier
//                 frame_tick           one pulse per frame
//                 bus (master)         char/attr RAM and font ROM port
//                 cur_addr/start/end   cursor cell and scanline range
//                 color, pixel_valid   pixel output
//               Macro: TEXT_ATTR_BLINK_EN (see vga_text_serializer)
//               COLS*ROWS must not exceed 2048.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_attr_pipe
    import vga_text_attr_pipe_pkg::*;
#(
    parameter int unsigned COLS = c_cols,
    parameter int unsigned ROWS = c_rows
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          h_count,
    input  logic [9:0]          v_count,
    input  logic                video_on,
    input  logic                frame_tick,
    vga_text_attr_pipe_if.master bus,
    input  logic [c_addr_w-1:0] cur_addr,
    input  logic [3:0]          cur_start,
    input  logic [3:0]          cur_end,
    output logic [3:0]          color,
    output logic                pixel_valid
);

    // Cycle t: fetch decision and cell address
    logic [4:0]          w_row;
    logic [3:0]          w_scan;
    logic                w_fetch;
    logic [c_addr_w-1:0] w_addr;
    logic                w_cur_hit;
    logic                w_unused_vmsb;

    logic [4:0]          r_frame;

    // t+1: RAM access
    logic [c_addr_w-1:0] r_ram_addr;
    logic                r_ram_cs;
    logic [3:0]          r_s1_scan;
    logic                r_s1_cursor;
    logic                r_s1_blink;

    // t+2: char/attr data back, font lookup
    logic                r_s2_valid;
    logic [3:0]          r_s2_scan;
    logic                r_s2_cursor;
    logic                r_s2_blink;

    // t+3: font row back, serializer load at end of cycle
    logic                r_s3_valid;
    logic [7:0]          r_s3_attr;
    logic                r_s3_cursor;
    logic                r_s3_blink;

    logic [c_pipe_lat-1:0] r_von_dly;

    assign w_row         = v_count[8:4];
    assign w_scan        = v_count[3:0];
    assign w_unused_vmsb = v_count[9];
    assign w_fetch       = video_on && (h_count[2:0] == 3'd0) &&
                           (32'(w_row) < ROWS);
    assign w_addr        = row_base(w_row, COLS) + 11'(h_count[9:3]);
    // An inverted range (start > end) can never satisfy both bounds.
    assign w_cur_hit     = (w_addr == cur_addr) && (cur_start <= w_scan) &&
                           (w_scan <= cur_end) && r_frame[3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame     <= '0;
            r_ram_addr  <= '0;
            r_ram_cs    <= 1'b0;
            r_s1_scan   <= '0;
            r_s1_cursor <= 1'b0;
            r_s1_blink  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_scan   <= '0;
            r_s2_cursor <= 1'b0;
            r_s2_blink  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s3_attr   <= '0;
            r_s3_cursor <= 1'b0;
            r_s3_blink  <= 1'b0;
            r_von_dly   <= '0;
        end else begin
            if (frame_tick) begin
                r_frame <= r_frame + 5'd1;
            end
            // Phase bits are taken from the pre-increment counter, so a
            // tick landing on a fetch only affects later fetches.
            r_ram_cs <= w_fetch;
            if (w_fetch) begin
                r_ram_addr  <= w_addr;
                r_s1_scan   <= w_scan;
                r_s1_cursor <= w_cur_hit;
                r_s1_blink  <= r_frame[4];
            end
            r_s2_valid  <= r_ram_cs;
            r_s2_scan   <= r_s1_scan;
            r_s2_cursor <= r_s1_cursor;
            r_s2_blink  <= r_s1_blink;
            // attr is held one extra stage so it changes together with the
            // shift register, not while the previous cell is still showing.
            r_s3_valid  <= r_s2_valid;
            r_s3_attr   <= bus.attr_data;
            r_s3_cursor <= r_s2_cursor;
            r_s3_blink  <= r_s2_blink;
            r_von_dly   <= {r_von_dly[c_pipe_lat-2:0], video_on};
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_cs    = r_ram_cs;
    // The font address must be presented in the same cycle the char byte
    // arrives to keep the total latency at four cycles.
    assign bus.font_addr = r_s2_valid ? {bus.char_data, r_s2_scan} : 12'd0;

    assign pixel_valid = r_von_dly[c_pipe_lat-1];

    vga_text_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_s3_valid),
        .i_font_bits (bus.font_data),
        .i_attr      (r_s3_attr),
        .i_cursor    (r_s3_cursor),
        .i_blink_ph  (r_s3_blink),
        .i_pix_valid (r_von_dly[c_pipe_lat-1]),
        .o_color     (color)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_text_attr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_text_attr_pipe
// Description : Self-checking bench for vga_text_attr_pipe.
//               - Models the char/attr RAM and the font ROM.
//               - Drives cells from a vector table plus hand sequences.
//               - Checks every pixel against a timestamped scoreboard.
//               Macro: TEXT_ATTR_BLINK_EN selects the blink expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_attr_pipe;
    import vga_text_attr_pipe_pkg::*;

    typedef struct {
        int         due;
        logic [3:0] col;
    } sb_t;

    typedef struct {
        logic [9:0]  v;
        logic [6:0]  col;
        logic [7:0]  ch;
        logic [7:0]  attr;
        logic [7:0]  font;
        logic [10:0] exp_addr;
        logic [31:0] exp_pix;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        video_on;
    logic        frame_tick;
    logic [10:0] cur_addr;
    logic [3:0]  cur_start;
    logic [3:0]  cur_end;
    logic [3:0]  color;
    logic        pixel_valid;

    logic [7:0]  char_mem [2048];
    logic [7:0]  attr_mem [2048];
    logic [7:0]  font_mem [4096];

    sb_t         sb_q[$];
    logic        sb_en;
    int          cyc;
    int          total;
    int          bad;

    vga_text_attr_pipe_if bus ();

    vga_text_attr_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .h_count     (h_count),
        .v_count     (v_count),
        .video_on    (video_on),
        .frame_tick  (frame_tick),
        .bus         (bus),
        .cur_addr    (cur_addr),
        .cur_start   (cur_start),
        .cur_end     (cur_end),
        .color       (color),
        .pixel_valid (pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: registered outputs, one cycle after the request.
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            bus.char_data <= char_mem[bus.ram_addr];
            bus.attr_data <= attr_mem[bus.ram_addr];
        end
        bus.font_data <= font_mem[bus.font_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every displayed pixel must match the entry
    // due on this exact cycle; idle cycles must show colour 0.
    always @(negedge clk) begin : p_check
        sb_t e;
        if (sb_en) begin
            if (pixel_valid) begin
                if (sb_q.size() == 0) begin
                    chk("pix_unexpected_valid", 32'(pixel_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pix_due", cyc, e.due);
                    chk("pix_color", 32'(color), 32'(e.col));
                end
            end else begin
                chk("idle_color", 32'(color), 32'd0);
                if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                    chk("pix_missing_valid", 32'(pixel_valid), 32'd1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            video_on   = 1'b0;
            frame_tick = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            video_on   = 1'b0;
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
        end
    endtask

    task automatic put_cell(input logic [10:0] a, input logic [7:0] ch,
                            input logic [7:0] at, input logic [3:0] scan,
                            input logic [7:0] font);
        char_mem[a]         = ch;
        attr_mem[a]         = at;
        font_mem[{ch, scan}] = font;
    endtask

    // Drives one 8-pixel cell, queues its expected pixels and checks the
    // RAM/font requests it causes.
    task automatic drive_cell(input string tag, input logic [9:0] v,
                              input logic [6:0] col,
                              input logic [10:0] exp_addr,
                              input logic [11:0] exp_faddr,
                              input logic [31:0] exp_pix,
                              input logic tk);
        sb_t e;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            v_count    = v;
            h_count    = {col, 3'(k)};
            video_on   = 1'b1;
            frame_tick = (k == 0) ? tk : 1'b0;
            e.due = cyc + 4;
            e.col = exp_pix[31-4*k -: 4];
            sb_q.push_back(e);
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_cs"}, 32'(bus.ram_cs), 32'd1);
                chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(exp_addr));
            end else if (k == 0 || k == 2) begin
                chk({tag, "_cs_low"}, 32'(bus.ram_cs), 32'd0);
            end
            if (k == 2) begin
                chk({tag, "_faddr"}, 32'(bus.font_addr), 32'(exp_faddr));
            end
        end
    endtask

    vec_t tbl[5];

    initial begin : p_timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : p_main
        sb_t e;
        total = 0;
        bad   = 0;
        sb_en = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            char_mem[i] = 8'h00;
            attr_mem[i] = 8'h00;
        end
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'h00;

        tbl[0] = '{10'd35,  7'd2,  8'h41, 8'h1E, 8'hF0, 11'd162,  32'hEEEE1111};
        tbl[1] = '{10'd0,   7'd0,  8'h00, 8'h2A, 8'hA5, 11'd0,    32'hA2A22A2A};
        tbl[2] = '{10'd399, 7'd79, 8'hFF, 8'h07, 8'h81, 11'd1999, 32'h70000007};
`ifdef TEXT_ATTR_BLINK_EN
        tbl[3] = '{10'd17,  7'd5,  8'h20, 8'h9E, 8'hF0, 11'd85,   32'h11111111};
`else
        tbl[3] = '{10'd17,  7'd5,  8'h20, 8'h9E, 8'hF0, 11'd85,   32'hEEEE9999};
`endif
        // Cursor cell with cur_phase still 0: renders normally.
        tbl[4] = '{10'd14,  7'd0,  8'h10, 8'h4C, 8'h3C, 11'd0,    32'h44CCCC44};

        rst        = 1'b0;
        h_count    = '0;
        v_count    = '0;
        video_on   = 1'b0;
        frame_tick = 1'b0;
        cur_addr   = 11'd0;
        cur_start  = 4'd14;
        cur_end    = 4'd15;
        bus.char_data = '0;
        bus.attr_data = '0;
        bus.font_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 32'(bus.ram_cs), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_faddr", 32'(bus.font_addr), 32'd0);
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_valid", 32'(pixel_valid), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b1;
        sb_en = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            put_cell(tbl[i].exp_addr, tbl[i].ch, tbl[i].attr,
                     tbl[i].v[3:0], tbl[i].font);
            drive_cell($sformatf("vec%0d", i), tbl[i].v, tbl[i].col,
                       tbl[i].exp_addr, {tbl[i].ch, tbl[i].v[3:0]},
                       tbl[i].exp_pix, 1'b0);
            idle(6);
        end

        // Two adjacent cells back to back: no gap between them.
        put_cell(11'd162, 8'h41, 8'h1E, 4'd3, 8'hF0);
        put_cell(11'd163, 8'h42, 8'h5A, 4'd3, 8'h0F);
        drive_cell("pair0", 10'd35, 7'd2, 11'd162, 12'h413, 32'hEEEE1111, 1'b0);
        drive_cell("pair1", 10'd35, 7'd3, 11'd163, 12'h423, 32'h5555AAAA, 1'b0);
        idle(6);

        // Cursor: frame counter 8 -> cur_phase 1.
        tick(8);
        put_cell(11'd0, 8'h10, 8'h4C, 4'd13, 8'h3C);
        put_cell(11'd0, 8'h10, 8'h4C, 4'd14, 8'h3C);
        put_cell(11'd0, 8'h10, 8'h4C, 4'd15, 8'h3C);
        put_cell(11'd1, 8'h10, 8'h4C, 4'd14, 8'h3C);
        drive_cell("cur13", 10'd13, 7'd0, 11'd0, 12'h10D, 32'h44CCCC44, 1'b0);
        drive_cell("cur14", 10'd14, 7'd0, 11'd0, 12'h10E, 32'hCCCCCCCC, 1'b0);
        drive_cell("cur14n", 10'd14, 7'd1, 11'd1, 12'h10E, 32'h44CCCC44, 1'b0);
        idle(6);
        drive_cell("cur15", 10'd15, 7'd0, 11'd0, 12'h10F, 32'hCCCCCCCC, 1'b0);
        idle(6);
        cur_start = 4'd15;
        cur_end   = 4'd14;
        drive_cell("cur_inv", 10'd14, 7'd0, 11'd0, 12'h10E, 32'h44CCCC44, 1'b0);
        idle(6);

        // Blink: counter 15 at the first fetch (tick coincides with it),
        // 16 at the second.
        tick(7);
        put_cell(11'd85, 8'h20, 8'h9E, 4'd1, 8'hF0);
        put_cell(11'd86, 8'h20, 8'h9E, 4'd1, 8'hF0);
`ifdef TEXT_ATTR_BLINK_EN
        drive_cell("blink15", 10'd17, 7'd5, 11'd85, 12'h201, 32'h11111111, 1'b1);
        drive_cell("blink16", 10'd17, 7'd6, 11'd86, 12'h201, 32'hEEEE1111, 1'b0);
`else
        drive_cell("blink15", 10'd17, 7'd5, 11'd85, 12'h201, 32'hEEEE9999, 1'b1);
        drive_cell("blink16", 10'd17, 7'd6, 11'd86, 12'h201, 32'hEEEE9999, 1'b0);
`endif
        idle(6);

        // Row 25 (v=400): no fetch, pixels valid but colour 0.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            v_count  = 10'd400;
            h_count  = 10'(k);
            video_on = 1'b1;
            e.due = cyc + 4;
            e.col = 4'd0;
            sb_q.push_back(e);
            @(negedge clk);
            chk("row25_cs", 32'(bus.ram_cs), 32'd0);
        end
        idle(1);
        @(negedge clk);
        chk("row25_cs_tail", 32'(bus.ram_cs), 32'd0);
        idle(6);

        // Reset in the middle of a displayed cell.
        chk("sb_before_rst", sb_q.size(), 32'd0);
        sb_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            v_count  = 10'd35;
            h_count  = 10'd16 + 10'(k);
            video_on = 1'b1;
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        video_on = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_color", 32'(color), 32'd0);
        chk("mid_rst_valid", 32'(pixel_valid), 32'd0);
        chk("mid_rst_frame", 32'(dut.r_frame), 32'd0);
        chk("mid_rst_cs", 32'(bus.ram_cs), 32'd0);
        sb_q.delete();
        sb_en = 1'b1;
        idle(8);
        drive_cell("post_rst", 10'd35, 7'd2, 11'd162, 12'h413, 32'hEEEE1111, 1'b0);
        idle(8);

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        sb_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_text_attr_pipe.md
VGA_TEXT_ATTR_PIPE -- requirements
Module: vga_text_attr_pipe

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per text row.
REQ-002 SHALL have parameter ROWS, default 25, text rows per frame; COLS*ROWS SHALL NOT exceed 2048.
REQ-003 SHALL have port clk, input, 1, the single clock (pixel rate); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port h_count, input, 10, pixel column from the timing generator.
REQ-006 SHALL have port v_count, input, 10, scanline from the timing generator.
REQ-007 SHALL have port video_on, input, 1, active-display qualifier for h_count and v_count.
REQ-008 SHALL have port frame_tick, input, 1, one-cycle pulse per frame.
REQ-009 SHALL have port ram_addr, output, 11, shared address to the character RAM and the 2K attribute RAM.
REQ-010 SHALL have port ram_cs, output, 1, RAM enable.
REQ-011 SHALL have ports char_data and attr_data, input, 8 each, registered RAM outputs valid one cycle after ram_cs.
REQ-012 SHALL have port font_addr, output, 12, value {char, scanline[3:0]}.
REQ-013 SHALL have port font_data, input, 8, font ROM output valid one cycle after font_addr; bit 7 is the leftmost pixel.
REQ-014 SHALL have ports cur_addr (input, 11), cur_start (input, 4) and cur_end (input, 4), the cursor cell and its scanline range.
REQ-015 SHALL have port color, output, 4, pixel palette index.
REQ-016 SHALL have port pixel_valid, output, 1, video_on delayed to align with color.

Function
REQ-017 SHALL fetch a cell in cycle t whenever video_on=1, h_count[2:0]=0 and v_count[8:4]<ROWS.
REQ-018 SHALL, on that fetch, register ram_addr=v_count[8:4]*COLS+h_count[9:3] and assert ram_cs for one cycle (t+1); the multiply SHALL be shift-add in 11 bits, max 1999.
REQ-019 SHALL hold ram_cs at 0 when no fetch occurs, including rows >= ROWS.
REQ-020 SHALL latch char_data and attr_data at t+2 and drive font_addr at t+2.
REQ-021 SHALL load an 8-bit shift register from font_data at the end of t+3 and shift it left once per cycle.
REQ-022 SHALL present the pixel for input cycle t+k (k=0..7) on color at t+k+4; latency SHALL be fixed at 4 cycles.
REQ-023 SHALL delay video_on 4 cycles to form pixel_valid; color SHALL be 0 when pixel_valid=0.
REQ-024 SHALL drive color = fg when the font bit is 1 and bg otherwise, with fg=attr[3:0].
REQ-025 SHALL count frame_tick in a 5-bit wrapping frame counter; blink_phase=bit4 and cur_phase=bit3.
REQ-026 SHALL apply the cursor when the cell address equals cur_addr, cur_start <= scanline <= cur_end and cur_phase=1: all 8 pixels of the cell SHALL then be fg.
REQ-027 SHALL show no cursor when cur_start > cur_end.
REQ-028 SHALL use the current frame counter value if frame_tick coincides with a fetch; the new value SHALL apply from the next fetch.
REQ-029 SHALL NOT stall; a new fetch every 8 cycles SHALL overlap the tail of the previous cell seamlessly.

Reset
REQ-030 SHALL, while rst=0, clear ram_addr, ram_cs, font_addr, color, pixel_valid, the shift register, the pipeline valid bits and the frame counter to 0.
REQ-031 SHALL make reset mid-line discard in-flight fetches; output SHALL resume at the first fetch condition after release.

Configuration
REQ-032 SHALL, with TEXT_ATTR_BLINK_EN defined, take bg=attr[6:4] zero-extended to 4 bits, with attr[7]=1 replacing fg by bg while blink_phase=0.
REQ-033 SHALL, without TEXT_ATTR_BLINK_EN, take bg=attr[7:4] and perform no blinking; the cursor is unaffected.

Structure
REQ-034 SHALL place constants COLS, ROWS, PIPE_LAT=4 and the field positions for attr fg/bg/blink in a shared package.
REQ-035 SHALL put the shift register and color select in one sub-module, vga_text_serializer.

Verification
REQ-036 Fetch SHALL be checked: h=16, v=35 (row 2, col 2) -> ram_addr=162, ram_cs high one cycle; font_addr={char, 4'd3}.
REQ-037 Pixel path SHALL be checked: font_data=8'hF0, attr=8'h1E -> colors E,E,E,E,1,1,1,1 starting 4 cycles after h[2:0]=0, with pixel_valid aligned.
REQ-038 Blink SHALL be checked: attr=8'h9E with TEXT_ATTR_BLINK_EN -> fg pixels show 1 for 16 frames, then E; without the macro, bg=9 and there is no blink.
REQ-039 Cursor SHALL be checked: cur_addr=0, start=14, end=15 -> scanlines 14-15 of cell 0 are all fg when cur_phase=1; cur_start=15, cur_end=14 -> no cursor.
REQ-040 Boundaries SHALL be checked: row 24, col 79 -> ram_addr=1999; v_count=400 -> ram_cs stays 0 and color=0.
REQ-041 Reset SHALL be checked: rst=0 mid-cell -> next cycle color=0, pixel_valid=0, frame counter=0; the next cell renders correctly.
